// File: rtl/usb11_pkt_gen.sv
// ---------------------------------------------------------------------------
// usb11_pkt_gen
// Builds USB 1.1 token, data and handshake packets one byte at a time for a
// downstream bit serializer. A one-cycle req in IDLE latches the packet
// fields. The block then presents SYNC, PID and the type-dependent body
// (token fields with CRC5, or payload with CRC16) on sbyte. It moves to the
// next byte on each show_next pulse.
//
// Ports
//   clk, rst                 12 MHz clock; asynchronous active-high reset
//   req                      one-cycle packet request (sampled in IDLE only)
//   pkt_type[1:0]            0 token, 1 data, 2/3 handshake
//   pid[3:0]                 PID code
//   addr[6:0], endp[3:0]     token address / endpoint
//   dat_len[3:0]             payload length (clamped to 8)
//   dat_idx[2:0]             payload index requested from the upstream buffer
//   dat_byte[7:0]            payload byte at dat_idx (combinational read)
//   sbyte[7:0]               byte to the serializer
//   start_pkt                pulse while SYNC is first presented
//   last_pkt_byte            high while sbyte holds the final packet byte
//   show_next                serializer request for the next byte
//   pkt_end                  serializer reports packet complete
//   eop                      frame EOP; aborts any packet in flight
//   busy                     packet in progress
//   done                     pulse on normal completion
//   aborted                  pulse when eop kills a packet
// ---------------------------------------------------------------------------
module usb11_pkt_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] pkt_type,
    input  logic [3:0] pid,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
    input  logic [3:0] dat_len,
    output logic [2:0] dat_idx,
    input  logic [7:0] dat_byte,
    output logic [7:0] sbyte,
    output logic       start_pkt,
    output logic       last_pkt_byte,
    input  logic       show_next,
    input  logic       pkt_end,
    input  logic       eop,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_TOK1, ST_TOK2,
        ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_WAIT_END
    } state_t;

    state_t      state, state_n;
    logic [7:0]  sbyte_n;
    logic        last_n, start_n, done_n, aborted_n;
    logic [3:0]  cnt, cnt_n;          // payload bytes loaded so far
    logic [15:0] crc16, crc16_n;      // reflected, non-inverted register
    logic [1:0]  type_r, type_n;
    logic [3:0]  pid_r, pid_n;
    logic [6:0]  addr_r, addr_n;
    logic [3:0]  endp_r, endp_n;
    logic [3:0]  len_r, len_n;
    logic [4:0]  crc5;
    logic        is_tok, is_data;

    // Reflected CRC16 (poly 0xA001), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Reflected CRC5 (x^5+x^2+1 -> 0x14 reflected) over addr then endp.
    // The reflected register already places the first-sent bit at bit 0,
    // so the inverted result drops straight into sbyte[7:3].
    function automatic logic [4:0] crc5_calc(input logic [10:0] d);
        logic [4:0] r;
        r = 5'h1F;
        for (int unsigned i = 0; i < 11; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 5'h14;
            else             r = r >> 1;
        end
        return ~r;
    endfunction

    assign crc5    = crc5_calc({endp_r, addr_r});
    assign is_tok  = (type_r == 2'd0);
    assign is_data = (type_r == 2'd1);
    assign busy    = (state != ST_IDLE);
    assign dat_idx = cnt[2:0];

    always_comb begin
        state_n   = state;
        sbyte_n   = sbyte;
        last_n    = last_pkt_byte;
        start_n   = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        cnt_n     = cnt;
        crc16_n   = crc16;
        type_n    = type_r;
        pid_n     = pid_r;
        addr_n    = addr_r;
        endp_n    = endp_r;
        len_n     = len_r;

        if (state == ST_IDLE) begin
            if (req && !eop) begin
                state_n = ST_SYNC;
                type_n  = pkt_type;
                pid_n   = pid;
                addr_n  = addr;
                endp_n  = endp;
                len_n   = (dat_len > 4'd8) ? 4'd8 : dat_len;
                sbyte_n = 8'h80;
                start_n = 1'b1;
                last_n  = 1'b0;
                cnt_n   = '0;
                crc16_n = '1;
            end
        end else if (eop) begin
            state_n   = ST_IDLE;
            aborted_n = 1'b1;
            last_n    = 1'b0;
            cnt_n     = '0;
        end else begin
            case (state)
                ST_SYNC: if (show_next) begin
                    state_n = ST_PID;
                    sbyte_n = {~pid_r, pid_r};
                    last_n  = !is_tok && !is_data;
                end
                ST_PID: if (show_next) begin
                    if (is_tok) begin
                        state_n = ST_TOK1;
                        sbyte_n = {endp_r[0], addr_r};
                    end else if (is_data) begin
                        if (len_r != 4'd0) begin
                            state_n = ST_DATA;
                            sbyte_n = dat_byte;
                            crc16_n = crc16_byte(crc16, dat_byte);
                            cnt_n   = 4'd1;
                        end else begin
                            state_n = ST_CRC_LO;
                            sbyte_n = ~crc16[7:0];
                        end
                    end else begin
                        state_n = ST_WAIT_END;
                    end
                end
                ST_TOK1: if (show_next) begin
                    state_n = ST_TOK2;
                    sbyte_n = {crc5, endp_r[3:1]};
                    last_n  = 1'b1;
                end
                ST_TOK2: if (show_next) state_n = ST_WAIT_END;
                ST_DATA: if (show_next) begin
                    if (cnt == len_r) begin
                        state_n = ST_CRC_LO;
                        sbyte_n = ~crc16[7:0];
                    end else begin
                        sbyte_n = dat_byte;
                        crc16_n = crc16_byte(crc16, dat_byte);
                        cnt_n   = cnt + 4'd1;
                    end
                end
                ST_CRC_LO: if (show_next) begin
                    state_n = ST_CRC_HI;
                    sbyte_n = ~crc16[15:8];
                    last_n  = 1'b1;
                end
                ST_CRC_HI: if (show_next) state_n = ST_WAIT_END;
                ST_WAIT_END: if (pkt_end) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    last_n  = 1'b0;
                    cnt_n   = '0;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sbyte         <= '0;
            last_pkt_byte <= 1'b0;
            start_pkt     <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            cnt           <= '0;
            crc16         <= '1;
            type_r        <= '0;
            pid_r         <= '0;
            addr_r        <= '0;
            endp_r        <= '0;
            len_r         <= '0;
        end else begin
            state         <= state_n;
            sbyte         <= sbyte_n;
            last_pkt_byte <= last_n;
            start_pkt     <= start_n;
            done          <= done_n;
            aborted       <= aborted_n;
            cnt           <= cnt_n;
            crc16         <= crc16_n;
            type_r        <= type_n;
            pid_r         <= pid_n;
            addr_r        <= addr_n;
            endp_r        <= endp_n;
            len_r         <= len_n;
        end
    end

endmodule

// File: tb/tb_usb11_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_usb11_pkt_gen
// Self-checking bench for usb11_pkt_gen: directed protocol packets, abort,
// reset and idle-robustness cases, then randomized packets checked against
// a byte-list reference model (non-reflected CRCs, bit-reversed at the end).
// ---------------------------------------------------------------------------
module tb_usb11_pkt_gen;

    logic       clk = 1'b0;
    logic       rst, req, show_next, pkt_end, eop;
    logic [1:0] pkt_type;
    logic [3:0] pid, endp, dat_len;
    logic [6:0] addr;
    logic [2:0] dat_idx;
    logic [7:0] dat_byte, sbyte;
    logic       start_pkt, last_pkt_byte, busy, done, aborted;

    logic [7:0] buf_mem [8];
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;
    assign dat_byte = buf_mem[dat_idx];

    usb11_pkt_gen dut (
        .clk(clk), .rst(rst), .req(req), .pkt_type(pkt_type), .pid(pid),
        .addr(addr), .endp(endp), .dat_len(dat_len), .dat_idx(dat_idx),
        .dat_byte(dat_byte), .sbyte(sbyte), .start_pkt(start_pkt),
        .last_pkt_byte(last_pkt_byte), .show_next(show_next), .pkt_end(pkt_end),
        .eop(eop), .busy(busy), .done(done), .aborted(aborted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // USB CRC5 in textbook MSB-first form; bits fed addr[0]..endp[3].
    function automatic logic [4:0] m_crc5(input logic [6:0] a, input logic [3:0] e);
        logic [4:0]  r;
        logic [10:0] bits;
        logic        fb;
        r = 5'h1F;
        bits = {e, a};
        for (int i = 0; i < 11; i++) begin
            fb = r[4] ^ bits[i];
            r  = {r[3:0], 1'b0};
            if (fb) r = r ^ 5'b00101;
        end
        r = ~r;
        return {r[0], r[1], r[2], r[3], r[4]};
    endfunction

    // USB CRC16 in non-reflected form (poly 0x8005), each byte LSB first.
    function automatic logic [15:0] m_crc16_reg(input logic [7:0] arr [10], input int n);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                fb = r[15] ^ arr[k][i];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        return r;
    endfunction

    function automatic logic [15:0] m_crc16_tx(input logic [15:0] r);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = r[15-i];
        return ~v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input int n);
        logic [7:0]  arr [10];
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(8'h80);
        exp_q.push_back({~p, p});
        if (t == 2'd0) begin
            exp_q.push_back({e[0], a});
            exp_q.push_back({m_crc5(a, e), e[3:1]});
        end else if (t == 2'd1) begin
            for (int k = 0; k < 10; k++) arr[k] = (k < n) ? buf_mem[k] : 8'h00;
            for (int k = 0; k < n; k++) exp_q.push_back(buf_mem[k]);
            c = m_crc16_tx(m_crc16_reg(arr, n));
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic send_req(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [3:0] l);
        pkt_type = t; pid = p; addr = a; endp = e; dat_len = l; req = 1'b1;
        tick();
        req = 1'b0;
        // scramble the inputs so only latched values can be used
        pkt_type = 2'($urandom); pid = 4'($urandom); addr = 7'($urandom);
        endp = 4'($urandom); dat_len = 4'($urandom);
    endtask

    task automatic run_pkt(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [3:0] l, input bit stray);
        int n, g;
        n = (l > 4'd8) ? 8 : int'(l);
        build_exp(t, p, a, e, n);
        obs_q.delete();
        send_req(t, p, a, e, l);
        check("start_pkt_sync", start_pkt, 1);
        check("sbyte_sync", sbyte, 8'h80);
        check("busy_sync", busy, 1);
        check("last_sync", last_pkt_byte, 0);
        obs_q.push_back(sbyte);
        for (int k = 1; k < exp_q.size(); k++) begin
            g = (stray && k == 2) ? 1 : int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
                if (stray && k == 2 && j == 0) begin
                    pkt_type = 2'd0; pid = 4'h9; req = 1'b1;
                end
                tick();
                req = 1'b0;
                check("start_hold", start_pkt, 0);
                check("sbyte_hold", sbyte, exp_q[k-1]);
                check("busy_hold", busy, 1);
            end
            if (t == 2'd1 && k >= 2 && k - 2 < n)
                check("dat_idx", dat_idx, 32'((k - 2) % 8));
            show_next = 1'b1;
            tick();
            show_next = 1'b0;
            check("sbyte", sbyte, exp_q[k]);
            check("last_pkt_byte", last_pkt_byte, (k == exp_q.size() - 1) ? 1 : 0);
            check("start_pkt_low", start_pkt, 0);
            obs_q.push_back(sbyte);
        end
        show_next = 1'b1;
        tick();
        show_next = 1'b0;
        check("wait_end_busy", busy, 1);
        check("wait_end_done", done, 0);
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("aborted_after_done", aborted, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    task automatic abort_pkt(input logic [1:0] t, input int adv);
        send_req(t, 4'h3, 7'h11, 4'h5, 4'd5);
        for (int k = 0; k < adv; k++) begin
            show_next = 1'b1;
            tick();
            show_next = 1'b0;
        end
        eop = 1'b1; show_next = 1'b1; pkt_end = 1'b1;
        tick();
        eop = 1'b0; show_next = 1'b0; pkt_end = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_last", last_pkt_byte, 0);
        check("abort_start", start_pkt, 0);
        tick();
        check("abort_one_cycle", aborted, 0);
        check("abort_no_done", done, 0);
    endtask

    initial begin
        logic [7:0]  arr [10];
        logic [7:0]  prev;
        rst = 1'b1; req = 1'b0; show_next = 1'b0; pkt_end = 1'b0; eop = 1'b0;
        pkt_type = '0; pid = '0; addr = '0; endp = '0; dat_len = '0;
        for (int i = 0; i < 8; i++) buf_mem[i] = 8'h00;
        repeat (3) tick();
        check("rst_sbyte", sbyte, 0);
        check("rst_dat_idx", dat_idx, 0);
        check("rst_start", start_pkt, 0);
        check("rst_last", last_pkt_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        rst = 1'b0;
        tick();

        // ACK handshake
        run_pkt(2'd2, 4'h2, 7'h00, 4'h0, 4'd0, 1'b0);
        check("ack_pid", obs_q[1], 8'hD2);
        // SETUP token to address 0 endpoint 0
        run_pkt(2'd0, 4'hD, 7'h00, 4'h0, 4'd0, 1'b0);
        check("setup_pid", obs_q[1], 8'h2D);
        check("setup_tok1", obs_q[2], 8'h00);
        check("setup_tok2", obs_q[3], 8'h10);
        // zero-length DATA0
        run_pkt(2'd1, 4'h3, 7'h00, 4'h0, 4'd0, 1'b0);
        check("zlp_pid", obs_q[1], 8'hC3);
        check("zlp_crc_lo", obs_q[2], 8'h00);
        check("zlp_crc_hi", obs_q[3], 8'h00);
        // 8-byte DATA0 with a stray req mid-packet; residual over payload+CRC
        buf_mem = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
        run_pkt(2'd1, 4'h3, 7'h00, 4'h0, 4'd8, 1'b1);
        for (int k = 0; k < 10; k++) arr[k] = obs_q[k + 2];
        check("crc16_residual", m_crc16_reg(arr, 10), 16'h800D);

        // eop during DATA and during the last token byte, then a clean packet
        abort_pkt(2'd1, 3);
        abort_pkt(2'd0, 3);
        run_pkt(2'd3, 4'hA, 7'h00, 4'h0, 4'd0, 1'b0);

        // idle robustness: show_next, pkt_end, req during eop
        prev = sbyte;
        show_next = 1'b1; tick(); show_next = 1'b0;
        check("idle_show_busy", busy, 0);
        check("idle_show_start", start_pkt, 0);
        check("idle_show_sbyte", sbyte, prev);
        pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        check("idle_pkt_end_done", done, 0);
        eop = 1'b1; req = 1'b1; tick(); eop = 1'b0; req = 1'b0;
        check("req_eop_busy", busy, 0);
        check("req_eop_start", start_pkt, 0);
        check("req_eop_aborted", aborted, 0);

        // asynchronous reset mid-packet
        send_req(2'd0, 4'h1, 7'h55, 4'hA, 4'd0);
        show_next = 1'b1; tick(); show_next = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sbyte", sbyte, 0);
        check("async_rst_idx", dat_idx, 0);
        tick();
        rst = 1'b0;
        check("rst_mid_done", done, 0);
        check("rst_mid_aborted", aborted, 0);
        tick();
        check("rst_mid_done2", done, 0);
        check("rst_mid_aborted2", aborted, 0);

        // randomized packets
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 8; i++) buf_mem[i] = 8'($urandom);
            run_pkt(2'($urandom), 4'($urandom), 7'($urandom), 4'($urandom),
                    4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
